// File: rtl/spike_counter_bank.sv
// spike_counter_bank: per-neuron saturating spike counters over a programmable window.
//
// A start_i pulse in IDLE or DONE clears the bank and loads the window length.
// The bank then counts spike_i for exactly window_len_i cycles, after which the
// counts are frozen and valid_o is held until the next accepted start or reset.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   start_i        one-cycle request to begin a counting window
//   window_len_i   window length in cycles (0 => immediate empty result)
//   spike_i        one spike bit per neuron per cycle
//   spike_counts_o packed counts, neuron k at [k*CNT_W +: CNT_W]
//   busy_o         high while counting
//   valid_o        high while counts hold a completed window
//   sat_o          sticky: some counter reached full scale this window
module spike_counter_bank #(
  parameter int unsigned N_NEURONS = 10,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned WIN_W     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [WIN_W-1:0]             window_len_i,
  input  logic [N_NEURONS-1:0]         spike_i,
  output logic [N_NEURONS*CNT_W-1:0]   spike_counts_o,
  output logic                         busy_o,
  output logic                         valid_o,
  output logic                         sat_o
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q [N_NEURONS];
  logic [CNT_W-1:0] cnt_d [N_NEURONS];
  logic [WIN_W-1:0] rem_q;
  logic             busy_q;
  logic             valid_q;
  logic             sat_q;
  logic             sat_hit;

  // Saturating increment; sat_hit flags any counter landing on full scale
  // (either reaching it now or being held there by another spike).
  always_comb begin
    sat_hit = 1'b0;
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (spike_i[k]) begin
        if (cnt_q[k] != CntMax) begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
        if (cnt_d[k] == CntMax) begin
          sat_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            rem_q <= window_len_i;
            sat_q <= 1'b0;
            for (int unsigned k = 0; k < N_NEURONS; k++) begin
              cnt_q[k] <= '0;
            end
            // A zero-length window completes immediately with empty counts.
            if (window_len_i == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              state_q <= StCount;
              busy_q  <= 1'b1;
              valid_q <= 1'b0;
            end
          end
        end
        StCount: begin
          // start_i is deliberately ignored: a running window cannot restart.
          for (int unsigned k = 0; k < N_NEURONS; k++) begin
            cnt_q[k] <= cnt_d[k];
          end
          sat_q <= sat_q | sat_hit;
          rem_q <= rem_q - WIN_W'(1);
          if (rem_q == WIN_W'(1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    spike_counts_o = '0;
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      spike_counts_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_spike_counter_bank.sv
// Bench for spike_counter_bank: directed window sequence with random spikes,
// expected counts derived from per-neuron spike totals clamped to full scale.
module tb_spike_counter_bank;

  localparam int N = 10;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [7:0]     len;
  logic [N-1:0]   spike;
  logic [N*W-1:0] counts;
  logic           busy;
  logic           valid;
  logic           sat;

  int checks = 0;
  int errors = 0;
  int sums [N];

  spike_counter_bank #(
    .N_NEURONS(N),
    .CNT_W    (W),
    .WIN_W    (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .window_len_i  (len),
    .spike_i       (spike),
    .spike_counts_o(counts),
    .busy_o        (busy),
    .valid_o       (valid),
    .sat_o         (sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spike pattern for cycle c (1-based) of a window; outside the window it is
  // random noise that the DUT must ignore.
  function automatic logic [N-1:0] gen(input int mode, input int c, input int wlen);
    logic [N-1:0] v;
    v = '0;
    if (c > wlen) return N'($urandom);
    case (mode)
      1: begin v[3] = 1'b1; v[7] = (c % 2 == 1); end
      2: v[0] = 1'b1;
      3: v[0] = (c == 5);
      4: v = '1;
      default: v = N'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_counts();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) begin
      v[k*W +: W] = (sums[k] > 255) ? 8'd255 : 8'(sums[k]);
    end
    return v;
  endfunction

  function automatic logic exp_sat();
    logic s;
    s = 1'b0;
    for (int k = 0; k < N; k++) if (sums[k] >= 255) s = 1'b1;
    return s;
  endfunction

  // Starts a window, runs until valid rises (bounded), checks timing and result.
  // Returns in the first DONE cycle so a following call starts back-to-back.
  task automatic do_window(input string name, input int wlen, input int mode,
                           input int restart_at);
    int first_valid;
    int busy_cycles;
    int c;
    first_valid = -1;
    busy_cycles = 0;
    c = 0;
    for (int k = 0; k < N; k++) sums[k] = 0;
    start = 1'b1;
    len   = 8'(wlen);
    spike = (mode == 4) ? '1 : N'($urandom);
    step();
    start = 1'b0;
    len   = 8'($urandom);
    if (valid) first_valid = 0;
    if (busy) busy_cycles++;
    chk({name, ":start_counts"}, 128'(counts), 128'(0));
    chk({name, ":start_busy"}, 128'(busy), 128'(wlen != 0));
    while (first_valid < 0 && c < wlen + 4) begin
      c++;
      spike = gen(mode, c, wlen);
      if (c <= wlen) begin
        for (int k = 0; k < N; k++) sums[k] += int'(spike[k]);
      end
      if (c == restart_at) begin
        start = 1'b1;
        len   = 8'd5;
      end
      step();
      start = 1'b0;
      if (busy) busy_cycles++;
      if (valid && first_valid < 0) first_valid = c;
    end
    chk({name, ":valid_at"}, 128'(first_valid), 128'(wlen));
    chk({name, ":busy_cycles"}, 128'(busy_cycles), 128'(wlen));
    chk({name, ":counts"}, 128'(counts), 128'(exp_counts()));
    chk({name, ":sat"}, 128'(sat), 128'(exp_sat()));
    chk({name, ":busy_done"}, 128'(busy), 128'(0));
  endtask

  task automatic hold(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      spike = N'($urandom);
      step();
    end
    chk({name, ":counts"}, 128'(counts), 128'(exp_counts()));
    chk({name, ":valid"}, 128'(valid), 128'(1));
    chk({name, ":sat"}, 128'(sat), 128'(exp_sat()));
  endtask

  initial begin
    logic seen_valid;
    rst   = 1'b1;
    start = 1'b0;
    len   = '0;
    spike = N'($urandom);
    step();
    spike = N'($urandom);
    step();
    chk("reset:counts", 128'(counts), 128'(0));
    chk("reset:busy", 128'(busy), 128'(0));
    chk("reset:valid", 128'(valid), 128'(0));
    chk("reset:sat", 128'(sat), 128'(0));

    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      spike = N'($urandom);
      step();
    end
    chk("idle:counts", 128'(counts), 128'(0));
    chk("idle:valid", 128'(valid), 128'(0));
    chk("idle:busy", 128'(busy), 128'(0));

    do_window("basic", 20, 1, 0);
    hold("basic_hold", 5);

    do_window("sat", 255, 2, 0);
    hold("sat_hold", 3);
    do_window("sat_clear", 10, 3, 0);

    do_window("zero", 0, 4, 0);
    hold("zero_hold", 2);

    do_window("ignore_start", 50, 0, 10);

    // Reset in the middle of a 30-cycle window.
    start = 1'b1;
    len   = 8'd30;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      spike = N'($urandom);
      step();
    end
    rst   = 1'b1;
    spike = N'($urandom);
    step();
    rst = 1'b0;
    chk("midrst:counts", 128'(counts), 128'(0));
    chk("midrst:busy", 128'(busy), 128'(0));
    chk("midrst:valid", 128'(valid), 128'(0));
    chk("midrst:sat", 128'(sat), 128'(0));
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      spike = N'($urandom);
      step();
      if (valid || busy) seen_valid = 1'b1;
    end
    chk("midrst:no_resume", 128'(seen_valid), 128'(0));

    do_window("b2b_a", 15, 0, 0);
    do_window("b2b_b", 12, 0, 0);

    for (int r = 0; r < 3; r++) begin
      do_window("rand", int'($urandom_range(1, 40)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
